// File: rtl/fan_pwm_drive.sv
// Motor PWM stage: kick from standstill, then linear duty ramp toward the per-gear target.
// Latency: duty/state change only at PWM period boundaries; pwm_out lags pwm_cnt/duty by one clk.
module fan_pwm_drive #(
    parameter int PRESCALE     = 500,
    parameter int PWM_PERIOD   = 100,
    parameter int KICK_PERIODS = 2,
    parameter int MIN_DUTY     = 30,
    parameter int STEP         = 5,
    parameter int RAMP_PERIODS = 4,
    parameter int DUTY_G1      = 40,
    parameter int DUTY_G2      = 70,
    parameter int DUTY_G3      = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
    input  logic [2:0] gear,
    output logic       pwm_out,
    output logic [6:0] duty,
    output logic       running,
    output logic       at_target
);
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int KICK_W = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
    localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_PERIODS - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
    localparam logic [6:0]        DUTY_FULL = 7'(PWM_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_KICK, S_RAMP, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [KICK_W-1:0]   kick_cnt_q, kick_cnt_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [6:0]          duty_q, duty_d;
    logic                pwm_out_q, pwm_out_d;

    logic       tick, period_end;
    logic [6:0] target;
    logic [7:0] duty_w, tgt_w, up_w, dn_w, stepped;
    logic [6:0] duty_step;

    always_comb begin
        target = '0;
        if (sw) begin
            case (gear)
                3'd1:    target = 7'(DUTY_G1);
                3'd2:    target = 7'(DUTY_G2);
                3'd3:    target = 7'(DUTY_G3);
                default: target = '0;
            endcase
        end
    end

    // One ramp step toward target in 8 bits so duty +/- STEP cannot wrap.
    always_comb begin
        duty_w  = {1'b0, duty_q};
        tgt_w   = {1'b0, target};
        up_w    = duty_w + 8'(STEP);
        dn_w    = (duty_w > 8'(STEP)) ? (duty_w - 8'(STEP)) : 8'd0;
        stepped = duty_w;
        if (tgt_w > duty_w) begin
            stepped = (up_w > tgt_w) ? tgt_w : up_w;
        end else if (tgt_w < duty_w) begin
            stepped = (dn_w < tgt_w) ? tgt_w : dn_w;
        end
        duty_step = (stepped[7] || (stepped[6:0] > DUTY_FULL)) ? DUTY_FULL : stepped[6:0];
    end

    assign tick       = (pre_cnt_q == PRE_LAST);
    assign period_end = tick && (pwm_cnt_q == CNT_LAST);

    always_comb begin
        pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d  = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + CNT_W'(1);
        end
        pwm_out_d  = (8'(pwm_cnt_q) < {1'b0, duty_q});
        state_d    = state_q;
        duty_d     = duty_q;
        kick_cnt_d = kick_cnt_q;
        ramp_cnt_d = ramp_cnt_q;

        if (period_end) begin
            case (state_q)
                S_IDLE: begin
                    if (target != '0) begin
                        state_d    = S_KICK;
                        duty_d     = DUTY_FULL;
                        kick_cnt_d = '0;
                    end
                end
                S_KICK: begin
                    if (target == '0) begin
                        state_d = S_IDLE;
                        duty_d  = '0;
                    end else if (kick_cnt_q == KICK_LAST) begin
                        state_d    = S_RAMP;
                        duty_d     = 7'(MIN_DUTY);
                        ramp_cnt_d = '0;
                    end else begin
                        kick_cnt_d = kick_cnt_q + KICK_W'(1);
                    end
                end
                S_RAMP: begin
                    if (ramp_cnt_q == RAMP_LAST) begin
                        ramp_cnt_d = '0;
                        duty_d     = duty_step;
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                    end
                    // Settling is judged on the post-step duty so RUN/IDLE is entered on the same boundary.
                    if (duty_d == target) begin
                        state_d = (target != '0) ? S_RUN : S_IDLE;
                    end
                end
                default: begin
                    if (target != duty_q) begin
                        ramp_cnt_d = '0;
                        state_d    = S_RAMP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            kick_cnt_q <= '0;
            ramp_cnt_q <= '0;
            duty_q     <= '0;
            pwm_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            kick_cnt_q <= kick_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            duty_q     <= duty_d;
            pwm_out_q  <= pwm_out_d;
        end
    end

    assign pwm_out   = pwm_out_q;
    assign duty      = duty_q;
    assign running   = (state_q != S_IDLE);
    assign at_target = (duty_q == target) && ((state_q == S_IDLE) || (state_q == S_RUN));

endmodule
